async_fifo_rd_stream: RTL and testbench

//  - Read-side consumer for the async FIFO; lives entirely in the rclk domain.
//  - Pops words via rinc/rempty/rdata and re-presents them as a valid/ready stream (m_*).
//  - Uses a 2-entry prefetch buffer, so full throughput is sustained under back-pressure.
//  - Provides an enable/drain FSM so software can stop reads cleanly.

---
 rtl/async_fifo_pkg.sv | 19 +
 rtl/rd_stream_skid.sv | 47 ++++
 rtl/async_fifo_rd_stream.sv | 132 +++++++++++++
 tb/tb_async_fifo_rd_stream.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types for the async FIFO read-side stream adapter.
// Holds the drain FSM encoding and the statistics counter width.
package async_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_e;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rd_stream_skid.sv
// Two-entry in-order prefetch buffer for the read stream.
// 1-bit read/write pointers plus an occupancy counter.
module rd_stream_skid
  import async_fifo_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [1:0]    o_occ,
  output logic [DW-1:0] o_head
);

  logic [DW-1:0] r_mem [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_occ;
  logic          w_pop;
  logic          w_push;

  // A push into a full buffer is only accepted alongside a pop.
  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rptr];

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-domain FIFO consumer: credit-based prefetch into a valid/ready stream.
// Optional pop/stall statistics when RD_STREAM_STATS_EN is defined.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 0,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  en,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy
`ifdef RD_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0]     pop_cnt,
  output logic [STAT_W-1:0]     stall_cnt
`endif
);

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("async_fifo_rd_stream: BUF_DEPTH must be 2");
  end
  if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_lat
    $error("async_fifo_rd_stream: RD_LATENCY must be 0 or 1");
  end

  localparam logic [2:0] LP_DEPTH = 3'(BUF_DEPTH);

  rd_state_e r_state;
  rd_state_e w_state_nxt;
  logic      w_run;

  logic [1:0]            w_occ;
  logic [1:0]            w_occ_after;
  logic [2:0]            w_used;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_inflight;

  assign m_valid     = (w_occ != 2'd0);
  assign m_data      = w_head;
  assign w_pop       = m_valid && m_ready;
  assign w_occ_after = w_occ - {1'b0, w_pop};
  assign w_used      = {1'b0, w_occ_after} + {2'b0, w_inflight};

  // Credit counts entries left after this cycle's pop plus the word in flight.
  assign rinc = w_run && !rempty && (w_used < LP_DEPTH);

  if (RD_LATENCY == 0) begin : g_lat0
    assign w_push     = rinc;
    assign w_inflight = 1'b0;
  end else begin : g_lat1
    logic r_inflight;
    always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) r_inflight <= 1'b0;
      else      r_inflight <= rinc;
    end
    assign w_push     = r_inflight;
    assign w_inflight = r_inflight;
  end

  rd_stream_skid #(
    .DW (DATA_WIDTH)
  ) u_skid (
    .i_clk  (rclk),
    .i_rst  (rrst),
    .i_push (w_push),
    .i_din  (rdata),
    .i_pop  (w_pop),
    .o_occ  (w_occ),
    .o_head (w_head)
  );

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (en) w_state_nxt = RUN;
      RUN:   if (!en) w_state_nxt = DRAIN;
      DRAIN: begin
        if (en)
          w_state_nxt = RUN;
        else if (w_occ_after == 2'd0 && !w_inflight)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_run = 1'b0;
    busy  = 1'b0;
    unique case (1'b1)
      (r_state == RUN):   begin w_run = 1'b1; busy = 1'b1; end
      (r_state == DRAIN): busy = 1'b1;
      default: ;
    endcase
  end

`ifdef RD_STREAM_STATS_EN
  logic [STAT_W-1:0] r_pop_cnt;
  logic [STAT_W-1:0] r_stall_cnt;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_pop_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (rinc)
        r_pop_cnt <= sat_inc(r_pop_cnt);
      if (m_valid && !m_ready)
        r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign pop_cnt   = r_pop_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: RD_LATENCY=0 and =1 instances run side by side.
// Each instance has its own FIFO model; beats are checked against the write order.
module tb_async_fifo_rd_stream;

  logic       rclk;
  logic       rrst;
  logic       en;
  logic       m_ready;
  logic       rempty  [2];
  logic [7:0] rdata   [2];
  logic       rinc    [2];
  logic [7:0] m_data  [2];
  logic       m_valid [2];
  logic       busy    [2];
`ifdef RD_STREAM_STATS_EN
  logic [15:0] pop_cnt   [2];
  logic [15:0] stall_cnt [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int rinc_tot [2];
  int beat_tot [2];
  int stall_tot[2];
  int viol     [2];
  int first_rinc[2];
  bit pop_pend  [2];
  bit prev_stall[2];
  logic [7:0] prev_data[2];

  logic [7:0] q     [2][$];
  logic [7:0] wq    [2][$];
  logic [7:0] got   [2][$];
  int         got_cyc[2][$];
  logic [7:0] exp_q [$];

  async_fifo_rd_stream #(
    .DATA_WIDTH (8),
    .RD_LATENCY (0),
    .BUF_DEPTH  (2)
  ) dut0 (
    .rclk      (rclk),
    .rrst      (rrst),
    .en        (en),
    .rempty    (rempty[0]),
    .rdata     (rdata[0]),
    .rinc      (rinc[0]),
    .m_data    (m_data[0]),
    .m_valid   (m_valid[0]),
    .m_ready   (m_ready),
    .busy      (busy[0])
`ifdef RD_STREAM_STATS_EN
    ,
    .pop_cnt   (pop_cnt[0]),
    .stall_cnt (stall_cnt[0])
`endif
  );

  async_fifo_rd_stream #(
    .DATA_WIDTH (8),
    .RD_LATENCY (1),
    .BUF_DEPTH  (2)
  ) dut1 (
    .rclk      (rclk),
    .rrst      (rrst),
    .en        (en),
    .rempty    (rempty[1]),
    .rdata     (rdata[1]),
    .rinc      (rinc[1]),
    .m_data    (m_data[1]),
    .m_valid   (m_valid[1]),
    .m_ready   (m_ready),
    .busy      (busy[1])
`ifdef RD_STREAM_STATS_EN
    ,
    .pop_cnt   (pop_cnt[1]),
    .stall_cnt (stall_cnt[1])
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FIFO models: instance 0 reads combinationally, instance 1 one cycle late.
  always @(posedge rclk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rrst) begin
        q[k].delete();
      end else begin
        if (pop_pend[k] && q[k].size() > 0) begin
          if (k == 1) rdata[1] = q[1].pop_front();
          else        void'(q[0].pop_front());
        end
        while (wq[k].size() > 0) q[k].push_back(wq[k].pop_front());
      end
      rempty[k] = (q[k].size() == 0);
    end
    rdata[0] = (q[0].size() > 0) ? q[0][0] : 8'h00;
  end

  // Observer: records beats, counts pops/stalls, flags protocol breaks.
  always @(negedge rclk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rrst) begin
        rinc_tot[k]   = 0;
        beat_tot[k]   = 0;
        stall_tot[k]  = 0;
        prev_stall[k] = 1'b0;
        pop_pend[k]   = 1'b0;
      end else begin
        pop_pend[k] = rinc[k];
        if (rinc[k]) begin
          rinc_tot[k]++;
          if (first_rinc[k] < 0) first_rinc[k] = cyc;
          if (rempty[k]) viol[k]++;
        end
        if (prev_stall[k] &&
            (!m_valid[k] || m_data[k] !== prev_data[k]))
          viol[k]++;
        if (m_valid[k] && m_ready) begin
          beat_tot[k]++;
          got[k].push_back(m_data[k]);
          got_cyc[k].push_back(cyc);
        end
        if (m_valid[k] && !m_ready) stall_tot[k]++;
        if (rinc_tot[k] - beat_tot[k] > 2) viol[k]++;
        prev_stall[k] = m_valid[k] && !m_ready;
        prev_data[k]  = m_data[k];
      end
    end
  end

  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  task automatic wr(input logic [7:0] w);
    wq[0].push_back(w);
    wq[1].push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    rrst    = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    step();
    step();
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      wq[k].delete();
      got[k].delete();
      got_cyc[k].delete();
      first_rinc[k] = -1;
      viol[k] = 0;
    end
    rrst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge rclk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m_valid[k] !== 1'b0 || rinc[k] !== 1'b0 ||
          busy[k] !== 1'b0 || m_data[k] !== 8'h00) begin
        errors++;
        $display("FAIL rst_init dut%0d v=%b rinc=%b busy=%b d=%h want 0",
                 k, m_valid[k], rinc[k], busy[k], m_data[k]);
      end
    end
    step();
    en = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'($urandom));
    repeat (6) step();
    @(negedge rclk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m_valid[k] !== 1'b1) begin
        errors++;
        $display("FAIL rst_pre_valid dut%0d got %b want 1", k, m_valid[k]);
      end
    end
    step();
    rrst = 1'b1;
    @(negedge rclk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m_valid[k] !== 1'b0 || rinc[k] !== 1'b0 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid dut%0d v=%b rinc=%b busy=%b want 0 0 0",
                 k, m_valid[k], rinc[k], busy[k]);
      end
`ifdef RD_STREAM_STATS_EN
      checks++;
      if (pop_cnt[k] !== 16'h0) begin
        errors++;
        $display("FAIL rst_popcnt dut%0d got %0d want 0", k, pop_cnt[k]);
      end
`endif
    end
    do_reset();
  endtask

  task automatic test_streaming();
    bit done;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(16 + i));
    step();
    step();
    en = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      step();
      done = (got[0].size() >= 16) && (got[1].size() >= 16);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL stream_timeout got %0d/%0d want 16/16",
               got[0].size(), got[1].size());
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k].size() !== 16) begin
        errors++;
        $display("FAIL stream_count dut%0d got %0d want 16", k, got[k].size());
      end else begin
        for (int i = 0; i < 16; i++) begin
          checks++;
          if (got[k][i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stream_data dut%0d beat %0d got %h want %h",
                     k, i, got[k][i], exp_q[i]);
          end
        end
        checks++;
        if (got_cyc[k][0] - first_rinc[k] !== 1 + k) begin
          errors++;
          $display("FAIL stream_latency dut%0d got %0d want %0d",
                   k, got_cyc[k][0] - first_rinc[k], 1 + k);
        end
        checks++;
        if (got_cyc[k][15] - got_cyc[k][0] !== 15) begin
          errors++;
          $display("FAIL stream_rate dut%0d span %0d want 15",
                   k, got_cyc[k][15] - got_cyc[k][0]);
        end
      end
      checks++;
      if (viol[k] !== 0) begin
        errors++;
        $display("FAIL stream_proto dut%0d got %0d want 0", k, viol[k]);
      end
    end
  endtask

  task automatic test_back_pressure();
    int r0[2];
    int n0[2];
    bit done;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(16 + i));
    step();
    step();
    en = 1'b1;
    for (int n = 0; n < 40 && got[0].size() < 2; n++) step();
    m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r0[k] = rinc_tot[k];
      n0[k] = got[k].size();
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge rclk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (m_valid[k] !== 1'b1 || m_data[k] !== exp_q[n0[k]]) begin
          errors++;
          $display("FAIL bp_hold dut%0d cyc %0d v=%b d=%h want 1 %h",
                   k, c, m_valid[k], m_data[k], exp_q[n0[k]]);
        end
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rinc_tot[k] - r0[k] > 2) begin
        errors++;
        $display("FAIL bp_rinc dut%0d got %0d want <=2", k, rinc_tot[k] - r0[k]);
      end
    end
    m_ready = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      step();
      done = (got[0].size() >= 16) && (got[1].size() >= 16);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k].size() !== 16) begin
        errors++;
        $display("FAIL bp_count dut%0d got %0d want 16", k, got[k].size());
      end else begin
        for (int i = 0; i < 16; i++) begin
          checks++;
          if (got[k][i] !== exp_q[i]) begin
            errors++;
            $display("FAIL bp_data dut%0d beat %0d got %h want %h",
                     k, i, got[k][i], exp_q[i]);
          end
        end
      end
      checks++;
      if (viol[k] !== 0) begin
        errors++;
        $display("FAIL bp_proto dut%0d got %0d want 0", k, viol[k]);
      end
    end
  endtask

  task automatic test_drain();
    int r0[2];
    int last[2];
    bit b[2][8];
    do_reset();
    for (int i = 0; i < 8; i++) wr(8'($urandom));
    step();
    step();
    en = 1'b1;
    repeat (6) step();
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r0[k]   = rinc_tot[k];
      last[k] = -1;
    end
    @(negedge rclk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rinc[k] !== 1'b0 || m_valid[k] !== 1'b1) begin
        errors++;
        $display("FAIL drain_start dut%0d rinc=%b v=%b want 0 1",
                 k, rinc[k], m_valid[k]);
      end
    end
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      for (int k = 0; k < 2; k++) begin
        b[k][i] = busy[k];
        if (m_valid[k] && m_ready) last[k] = i;
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k].size() !== 2) begin
        errors++;
        $display("FAIL drain_count dut%0d got %0d want 2", k, got[k].size());
      end else begin
        checks++;
        if (got[k][0] !== exp_q[0] || got[k][1] !== exp_q[1]) begin
          errors++;
          $display("FAIL drain_data dut%0d got %h %h want %h %h",
                   k, got[k][0], got[k][1], exp_q[0], exp_q[1]);
        end
      end
      checks++;
      if (rinc_tot[k] !== r0[k]) begin
        errors++;
        $display("FAIL drain_rinc dut%0d got %0d want 0", k, rinc_tot[k] - r0[k]);
      end
      checks++;
      if (last[k] < 0 || last[k] > 6) begin
        errors++;
        $display("FAIL drain_busy dut%0d last beat %0d want 0..6", k, last[k]);
      end else if (b[k][last[k]] !== 1'b1 || b[k][last[k] + 1] !== 1'b0) begin
        errors++;
        $display("FAIL drain_busy dut%0d got %b%b want 10",
                 k, b[k][last[k]], b[k][last[k] + 1]);
      end
    end
    do_reset();
  endtask

  task automatic test_empty();
    do_reset();
    en = 1'b1;
    m_ready = 1'b1;
    repeat (5) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rinc_tot[k] !== 0) begin
        errors++;
        $display("FAIL empty_idle dut%0d got %0d rinc want 0", k, rinc_tot[k]);
      end
    end
    wr(8'hA5);
    repeat (8) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rinc_tot[k] !== 1) begin
        errors++;
        $display("FAIL empty_rinc dut%0d got %0d want 1", k, rinc_tot[k]);
      end
      checks++;
      if (got[k].size() !== 1) begin
        errors++;
        $display("FAIL empty_count dut%0d got %0d want 1", k, got[k].size());
      end else begin
        checks++;
        if (got[k][0] !== 8'hA5) begin
          errors++;
          $display("FAIL empty_data dut%0d got %h want a5", k, got[k][0]);
        end
      end
      checks++;
      if (viol[k] !== 0 || busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL empty_state dut%0d viol=%0d busy=%b want 0 1",
                 k, viol[k], busy[k]);
      end
    end
    en = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_alt_ready(input bit rnd_en, input int nwords);
    int written;
    bit done;
    do_reset();
    en = 1'b1;
    written = 0;
    for (int n = 0; n < 400 && written < nwords; n++) begin
      m_ready = rnd_en ? 1'($urandom_range(0, 1)) : ~m_ready;
      if (rnd_en) en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) begin
        wr(8'($urandom));
        written++;
      end
      step();
    end
    en = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      m_ready = rnd_en ? 1'($urandom_range(0, 1)) : ~m_ready;
      step();
      done = (got[0].size() >= exp_q.size()) && (got[1].size() >= exp_q.size());
    end
    m_ready = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (got[k].size() !== exp_q.size()) begin
        errors++;
        $display("FAIL alt_count dut%0d rnd %0d got %0d want %0d",
                 k, rnd_en, got[k].size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (got[k][i] !== exp_q[i]) begin
            errors++;
            $display("FAIL alt_data dut%0d rnd %0d beat %0d got %h want %h",
                     k, rnd_en, i, got[k][i], exp_q[i]);
          end
        end
      end
      checks++;
      if (viol[k] !== 0) begin
        errors++;
        $display("FAIL alt_proto dut%0d rnd %0d got %0d want 0", k, rnd_en, viol[k]);
      end
`ifdef RD_STREAM_STATS_EN
      checks++;
      if (stall_cnt[k] !== 16'(stall_tot[k])) begin
        errors++;
        $display("FAIL alt_stallcnt dut%0d got %0d want %0d",
                 k, stall_cnt[k], stall_tot[k]);
      end
      checks++;
      if (pop_cnt[k] !== 16'(rinc_tot[k])) begin
        errors++;
        $display("FAIL alt_popcnt dut%0d got %0d want %0d",
                 k, pop_cnt[k], rinc_tot[k]);
      end
`endif
    end
  endtask

  initial begin
    rrst    = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rempty[k]     = 1'b1;
      rdata[k]      = 8'h00;
      rinc_tot[k]   = 0;
      beat_tot[k]   = 0;
      stall_tot[k]  = 0;
      viol[k]       = 0;
      first_rinc[k] = -1;
      pop_pend[k]   = 1'b0;
      prev_stall[k] = 1'b0;
      prev_data[k]  = 8'h00;
    end
    test_reset();
    test_streaming();
    test_back_pressure();
    test_drain();
    test_empty();
    test_alt_ready(1'b0, 24);
    test_alt_ready(1'b1, 120);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
